// File: rtl/guess_pkg.sv
// Shared types and pattern helpers for the guess game core and its lamp walker.
package guess_pkg;

    localparam int unsigned MaxN = 16;

    typedef enum logic [1:0] {
        StPlay,
        StWin,
        StLose,
        StOver
    } guess_state_t;

    function automatic logic [MaxN-1:0] onehot(input int unsigned idx, input int unsigned n);
        logic [MaxN-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < MaxN; i++) begin
            if (i < n && i == idx) v[i] = 1'b1;
        end
        return v;
    endfunction

    // Inner lamps lit, both end lamps dark.
    function automatic logic [MaxN-1:0] lose_pattern(input int unsigned n);
        logic [MaxN-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < MaxN; i++) begin
            if (i >= 1 && i + 1 < n) v[i] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/guess_walker.sv
// Lamp position counter: wraps N-1 -> 0, or bounces end to end when GUESS_PINGPONG_EN is defined.
module guess_walker #(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = $clog2(N)
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          step_i,
    input  logic          restart_i,
    output logic [PW-1:0] pos_o
);

    localparam logic [PW-1:0] Last = PW'(N - 1);

    logic [PW-1:0] pos_q, pos_d;

`ifdef GUESS_PINGPONG_EN
    logic dir_up_q, dir_up_d;

    always_comb begin
        pos_d    = pos_q;
        dir_up_d = dir_up_q;
        if (restart_i) begin
            pos_d    = '0;
            dir_up_d = 1'b1;
        end else if (step_i) begin
            if (dir_up_q) begin
                if (pos_q == Last) begin
                    dir_up_d = 1'b0;
                    pos_d    = pos_q - PW'(1);
                end else begin
                    pos_d = pos_q + PW'(1);
                end
            end else begin
                if (pos_q == '0) begin
                    dir_up_d = 1'b1;
                    pos_d    = PW'(1);
                end else begin
                    pos_d = pos_q - PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pos_q    <= '0;
            dir_up_q <= 1'b1;
        end else begin
            pos_q    <= pos_d;
            dir_up_q <= dir_up_d;
        end
    end
`else
    always_comb begin
        pos_d = pos_q;
        if (restart_i) begin
            pos_d = '0;
        end else if (step_i) begin
            pos_d = (pos_q == Last) ? '0 : pos_q + PW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) pos_q <= '0;
        else         pos_q <= pos_d;
    end
`endif

    assign pos_o = pos_q;

endmodule

// File: rtl/guess_game_core.sv
// Reaction guessing game: lamp walks over N channels, hits score, misses cost lives.
// Lamp motion is bouncing when GUESS_PINGPONG_EN is defined, wrapping otherwise.
module guess_game_core
    import guess_pkg::*;
#(
    parameter int unsigned N       = 4,
    parameter int unsigned SCORE_W = 4,
    parameter int unsigned LIVES   = 3,
    localparam int unsigned LW     = $clog2(LIVES + 1),
    localparam int unsigned PW     = $clog2(N)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               en_i,
    input  logic [N-1:0]       b_i,
    output logic [N-1:0]       y_o,
    output logic               win_o,
    output logic               lose_o,
    output logic               game_over_o,
    output logic [SCORE_W-1:0] score_o,
    output logic [LW-1:0]      lives_left_o
);

    guess_state_t       state_q;
    logic [SCORE_W-1:0] score_q;
    logic [LW-1:0]      lives_q;
    logic [PW-1:0]      pos;
    logic [N-1:0]       lamp;
    logic               b_none, b_all, step, restart;

    assign lamp   = N'(onehot(32'(pos), N));
    assign b_none = (b_i == '0);
    assign b_all  = (b_i == '1);
    assign step   = en_i && (state_q == StPlay) && b_none;
    assign restart = en_i && ((((state_q == StWin) || (state_q == StLose)) && b_none) ||
                              ((state_q == StOver) && b_all));

    guess_walker #(
        .N  (N),
        .PW (PW)
    ) u_walker (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .step_i    (step),
        .restart_i (restart),
        .pos_o     (pos)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StPlay;
            score_q <= '0;
            lives_q <= LW'(LIVES);
        end else if (en_i) begin
            unique case (state_q)
                StPlay: begin
                    if (b_i == lamp) begin
                        state_q <= StWin;
                        if (score_q != '1) score_q <= score_q + SCORE_W'(1);
                    end else if (!b_none) begin
                        lives_q <= lives_q - LW'(1);
                        state_q <= (lives_q == LW'(1)) ? StOver : StLose;
                    end
                end
                StWin, StLose: begin
                    if (b_none) state_q <= StPlay;
                end
                StOver: begin
                    if (b_all) begin
                        state_q <= StPlay;
                        score_q <= '0;
                        lives_q <= LW'(LIVES);
                    end
                end
            endcase
        end
    end

    // Moore decode: outputs depend on state and pos only.
    always_comb begin
        y_o         = '0;
        win_o       = 1'b0;
        lose_o      = 1'b0;
        game_over_o = 1'b0;
        unique case (state_q)
            StPlay: y_o = lamp;
            StWin: begin
                y_o   = '1;
                win_o = 1'b1;
            end
            StLose: begin
                y_o    = N'(lose_pattern(N));
                lose_o = 1'b1;
            end
            StOver: begin
                lose_o      = 1'b1;
                game_over_o = 1'b1;
            end
        endcase
    end

    assign score_o      = score_q;
    assign lives_left_o = lives_q;

endmodule

// File: doc/guess_game_core.md
# guess_game_core

Parametrised successor to the four-LED reaction guessing game. A one-hot lamp walks across N channels on each enable tick. The player presses the matching button to score; a wrong press costs a life, and exhausting all lives ends the game. It sits between the debounced button/tick front end and the LED/seven-segment display logic, and exports score and remaining lives for display.

## Interface
Parameters:
- N, 4: number of lamp/button channels; legal range 3..16.
- SCORE_W, 4: score counter width.
- LIVES, 3: lives per game; legal range 1..7.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  reset, synchronous, active-high.
- en  input  1  game tick; all state changes occur only on clk edges with en=1.
- b  input  N  debounced buttons, active-high.
- y  output  N  lamp pattern.
- win  output  1  high in WIN state.
- lose  output  1  high in LOSE and OVER states.
- game_over  output  1  high in OVER state.
- score  output  SCORE_W  hits this game.
- lives_left  output  LW  remaining lives, LW = $clog2(LIVES+1).

## Operation
- States: PLAY, WIN, LOSE, OVER. Internal lamp index pos (0..N-1).
- PLAY: y = one-hot(pos). On tick:
  - b == 0: advance pos (see Configuration); stay in PLAY.
  - b == one-hot(pos) exactly: go to WIN; score += 1, saturating at 2^SCORE_W-1.
  - Otherwise (wrong bit, or multiple bits even if the correct one is included): lives_left -= 1. Go to OVER if lives_left was 1, else to LOSE.
- WIN: y = all ones, win=1. Holds while b != 0. First tick with b == 0 goes to PLAY with pos=0 and direction reset.
- LOSE: y = bits 1..N-2 set, bits 0 and N-1 clear (N=4 gives 0110), lose=1. Holds while b != 0. First tick with b == 0 goes to PLAY with pos=0.
- OVER: y = 0, lose=1, game_over=1. A tick with b == all ones restarts the game: PLAY, pos=0, score=0, lives_left=LIVES. Any other input stays in OVER.
- win, lose, game_over and y are decoded from state and pos only (Moore). They never depend combinationally on b.

## Timing
- Reset: state=PLAY, pos=0, direction=up, score=0, lives_left=LIVES. Resulting outputs: y=one-hot(0), win=0, lose=0, game_over=0.
- Reset takes priority over en on the same edge. Asserting reset mid-game, in any state, returns to the reset values on the next edge.
- A transition and its score/lives update land on the same clk edge. Outputs reflect the new state in the following cycle.
- en=0: all registers hold regardless of b.
- Score at maximum plus a hit: score holds its value; the state still goes to WIN.
- Hit and tick on the final pos: a hit wins and does not advance.

## Configuration
- GUESS_PINGPONG_EN defined: the lamp bounces. pos goes 0→N-1, reverses, goes N-1→0, and repeats, with period 2N-2 ticks. A direction register is present, reset to up.
- GUESS_PINGPONG_EN undefined: pos wraps from N-1 to 0, with period N ticks. No direction register is present.

## Structure
- Package guess_pkg holds:
  - the state enum typedef guess_state_t (PLAY, WIN, LOSE, OVER);
  - the function onehot(idx, N);
  - the function lose_pattern(N).
- Sub-module guess_walker holds the pos counter with optional direction. Inputs: clk, reset, step, restart. Output: pos.
- The core instantiates guess_walker once.

## Test plan
- Reset with N=4, no press, 5 ticks: y sequence 0001, 0010, 0100, 1000, 0001, 0010. With GUESS_PINGPONG_EN: 0001, 0010, 0100, 1000, 0100, 0010.
- Hit: at y=0100, b=0100 on a tick → win=1, y=1111, score=1. Hold b for 3 ticks → stays WIN. Release b → PLAY, y=0001.
- Miss: at y=0010, b=0011 on a tick → LOSE, y=0110, lives_left=2. Release → PLAY, y=0001.
- Game over: 3 misses with LIVES=3 → game_over=1, lose=1, y=0000, lives_left=0. b=0101 on a tick → stays OVER. b=1111 on a tick → PLAY, score=0, lives_left=3.
- Saturation: SCORE_W=2, 4 hits → score=3 and stays 3. The WIN state is still entered on the 4th hit.
- en gating and reset: hold en=0 for 10 cycles with b toggling → no change. Assert reset in WIN with en=1 → next cycle has PLAY reset values.
